axil_sram_slave: RTL and testbench
==================================

// Module: axil_sram_slave
// PURPOSE
//  Parametrised AXI4-Lite slave SRAM; successor of the fixed 128-bit/64 KiB byte-array SRAM.
//  Independent read and write channels. Byte-strobed writes. Registered read data.
//  Full AXI-Lite response signalling (rresp/bresp) with SLVERR on out-of-range access.
//  Sits behind the system interconnect as the shared data/weight memory.
// PARAMETERS
//  DATA_W    128    data bus width in bits; power of two, >=32; DATA_BYTES = DATA_W/8
//  ADDR_W    32     AXI address width; only the low log2(MEM_BYTES) bits index memory
//  MEM_BYTES 65536  memory size in bytes; power of two, multiple of DATA_BYTES
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           reset, asynchronous, active-high
//  araddr   in   ADDR_W      read address (byte address)
//  arvalid  in   1           read address valid
//  arready  out  1           read address ready
//  rdata    out  DATA_W      read data, byte 0 in [7:0]
//  rresp    out  2           read response: 2'b00 OKAY, 2'b10 SLVERR
//  rvalid   out  1           read data valid
//  rready   in   1           read data ready
//  awaddr   in   ADDR_W      write address (byte address)
//  awvalid  in   1           write address valid
//  awready  out  1           write address ready
//  wdata    in   DATA_W      write data
//  wstrb    in   DATA_W/8    byte-lane write enables
//  wvalid   in   1           write data valid
//  wready   out  1           write data ready
//  bresp    out  2           write response: OKAY / SLVERR
//  bvalid   out  1           write response valid
//  bready   in   1           write response ready
// BEHAVIOUR
//  Reset: rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs to IDLE, so arready=awready=wready=1.
//  Reset mid-transaction abandons it; no memory write after reset is asserted. Memory contents are not reset.
//  Address: low log2(DATA_BYTES) bits are dropped (aligned down). Out-of-range = addr >= MEM_BYTES.
//  Read FSM R_IDLE -> R_DATA:
//   arready = (state==R_IDLE). AR handshake at edge N latches the word.
//   At edge N+1, rvalid=1 with rdata/rresp.
//   Hold rdata/rresp/rvalid stable until rready; R_DATA -> R_IDLE on rvalid&rready.
//   Next AR is accepted no earlier than the cycle after the R handshake.
//   Out of range: rresp=SLVERR, rdata=0.
//  Write FSM W_IDLE / W_WAIT_DATA / W_WAIT_ADDR / W_WRITE / W_RESP:
//   awready = state in {W_IDLE, W_WAIT_ADDR}; wready = state in {W_IDLE, W_WAIT_DATA}.
//   Transitions from W_IDLE:
//    both valid -> W_WRITE; AW only -> W_WAIT_DATA; W only -> W_WAIT_ADDR.
//   Waits complete on the missing valid -> W_WRITE.
//   W_WRITE, one cycle: byte lane i written iff wstrb[i] and in range.
//   wstrb=0 is legal; it writes nothing and returns OKAY.
//   W_RESP: bvalid=1; bresp=SLVERR if out of range, else OKAY.
//   Exit to W_IDLE on bready. No new AW/W is accepted while in W_WRITE or W_RESP.
//  Read/write collision: read latching the same word in the W_WRITE cycle returns OLD data (read-before-write).
//  Address wrap: a word never straddles MEM_BYTES, since addresses are aligned.
// CONFIGURATION
//  AXIL_SRAM_ALIGN_CHECK_EN defined:
//   addr[log2(DATA_BYTES)-1:0] != 0 -> SLVERR.
//   Read returns rdata=0; write is suppressed.
//  Not defined: low bits are silently ignored, with no error.
// STRUCTURE
//  Package axil_sram_pkg:
//   RESP_OKAY=2'b00, RESP_SLVERR=2'b10
//   read/write state encodings
//   clog2 helper for DATA_BYTES/MEM_BYTES index widths
//  Sub-module axil_sram_bytearray:
//   DATA_BYTES lanes x (MEM_BYTES/DATA_BYTES) words
//   1 sync read port + 1 write port with per-lane enable
//   read-before-write on same-word collision
// TESTING
//  1 AW+W same cycle: addr 0x40, wdata=0x00..0F bytes, wstrb=16'hFFFF, bready=1
//    -> bvalid 2 cycles after handshake, bresp=OKAY; read 0x40 returns same data.
//  2 Partial strobe: write 0x40 with wstrb=16'h0001, wdata byte0=0xAA -> read 0x40 gives byte0=0xAA, bytes1..15 unchanged.
//  3 W before AW by 3 cycles: addr 0x80 -> FSM waits in W_WAIT_ADDR, awready=1, wready=0; single write, one bvalid.
//  4 Backpressure: rready=0 for 5 cycles after rvalid -> rdata/rresp stable, arready=0 throughout; next read accepted after handshake.
//  5 Out of range: read/write 0x10000 with MEM_BYTES=65536 -> rresp=SLVERR, rdata=0, bresp=SLVERR; memory unchanged.
//  6 Collision/reset: read 0x40 on the W_WRITE cycle of a write to 0x40 -> old data.
//    rst asserted in W_RESP -> bvalid=0 next cycle, awready=1.
//  Repeat tests 1-5 with AXIL_SRAM_ALIGN_CHECK_EN: addr 0x41 -> SLVERR, no write.

Source files
------------

// File: rtl/axil_sram_pkg.sv
// Shared constants, FSM encodings and index-width helper for the AXI4-Lite SRAM slave.
package axil_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_WRITE,
    W_RESP
  } w_state_t;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_sram_bytearray.sv
// Word-organised byte-lane SRAM: one registered read port, one lane-enabled write port.
// A read and a write to the same word on the same edge returns the pre-write contents.
module axil_sram_bytearray #(
  parameter int DATA_BYTES = 16,
  parameter int WORDS      = 4096,
  parameter int IDX_W      = 12
) (
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_BYTES*8-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_BYTES-1:0]   wr_lane,
  input  logic [DATA_BYTES*8-1:0] wr_data
);

  logic [DATA_BYTES-1:0][7:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (wr_en) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (wr_lane[i]) mem[wr_idx][i] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM slave: read data valid two edges after AR, write response after a one-cycle write.
// AXIL_SRAM_ALIGN_CHECK_EN turns misaligned addresses into SLVERR; otherwise low bits are ignored.
module axil_sram_slave import axil_sram_pkg::*; #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int OFF_W      = clog2(DATA_BYTES);
  localparam int MEM_AW     = clog2(MEM_BYTES);
  localparam int IDX_W      = MEM_AW - OFF_W;
  localparam int WORDS      = MEM_BYTES / DATA_BYTES;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic e;
    e = ({1'b0, a} >= MEM_LIMIT);
`ifdef AXIL_SRAM_ALIGN_CHECK_EN
    e = e | (a[OFF_W-1:0] != '0);
`endif
    return e;
  endfunction

  logic              ar_hs, aw_hs, w_hs;
  logic [DATA_W-1:0] arr_rdata;
  logic              r_load_q, r_err_q;
  r_state_t          r_state, r_state_nxt;
  w_state_t          w_state, w_state_nxt;
  logic [ADDR_W-1:0]     w_addr_q;
  logic [DATA_W-1:0]     w_data_q;
  logic [DATA_BYTES-1:0] w_strb_q;
  logic                  w_err;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign w_err = addr_err(w_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nxt = R_DATA;
      end
      R_DATA:  if (rvalid && rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Array captures the word on the AR edge; the response registers load one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_q <= 1'b0;
      r_err_q  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      r_load_q <= ar_hs;
      if (ar_hs) r_err_q <= addr_err(araddr);
      if (r_load_q) begin
        rvalid <= 1'b1;
        rdata  <= r_err_q ? '0 : arr_rdata;
        rresp  <= r_err_q ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) w_state_nxt = W_WRITE;
        else if (awvalid)      w_state_nxt = W_WAIT_DATA;
        else if (wvalid)       w_state_nxt = W_WAIT_ADDR;
      end
      W_WAIT_DATA: begin
        wready = 1'b1;
        if (wvalid) w_state_nxt = W_WRITE;
      end
      W_WAIT_ADDR: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = W_WRITE;
      end
      W_WRITE: w_state_nxt = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign bresp = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) w_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  axil_sram_bytearray #(
    .DATA_BYTES (DATA_BYTES),
    .WORDS      (WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (ar_hs),
    .rd_idx  (araddr[MEM_AW-1:OFF_W]),
    .rd_data (arr_rdata),
    .wr_en   ((w_state == W_WRITE) && !w_err),
    .wr_idx  (w_addr_q[MEM_AW-1:OFF_W]),
    .wr_lane (w_strb_q),
    .wr_data (w_data_q)
  );

endmodule

// File: tb/tb_axil_sram_slave.sv
// Scoreboard bench for axil_sram_slave: byte-array reference model, directed cases, random traffic.
module tb_axil_sram_slave;
  import axil_sram_pkg::*;

  localparam int DATA_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 65536;
  localparam int DB        = DATA_W / 8;
`ifdef AXIL_SRAM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b1;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DATA_W-1:0] wdata = '0;
  logic [DB-1:0]     wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rexp_t;

  rexp_t      r_q[$];
  logic [1:0] b_q[$];
  int         tests = 0;
  int         fails = 0;
  int         r_seen = 0;
  int         b_seen = 0;
  bit         bp_rand = 1'b0;
  logic [7:0] mem_m [MEM_BYTES];

  axil_sram_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit is_err(input logic [ADDR_W-1:0] a);
    return (a >= MEM_BYTES) || (ALIGN_CHK && (a[3:0] != 4'h0));
  endfunction

  function automatic rexp_t model_read(input logic [ADDR_W-1:0] a);
    rexp_t e;
    int    base;
    e.data = '0;
    e.resp = is_err(a) ? RESP_SLVERR : RESP_OKAY;
    if (!is_err(a)) begin
      base = int'(a[15:0]) & ~(DB - 1);
      for (int i = 0; i < DB; i++) e.data[i*8 +: 8] = mem_m[base + i];
    end
    return e;
  endfunction

  function automatic logic [1:0] model_write(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] d, input logic [DB-1:0] s);
    int base;
    if (is_err(a)) return RESP_SLVERR;
    base = int'(a[15:0]) & ~(DB - 1);
    for (int i = 0; i < DB; i++) if (s[i]) mem_m[base + i] = d[i*8 +: 8];
    return RESP_OKAY;
  endfunction

  // Monitor: pops the scoreboard at every R/B handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_unexpected: got rvalid with empty scoreboard, required none");
        end else begin
          rexp_t e;
          e = r_q.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", DATA_W'(rresp), DATA_W'(e.resp));
        end
        r_seen++;
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected: got bvalid with empty scoreboard, required none");
        end else begin
          logic [1:0] eb;
          eb = b_q.pop_front();
          check("bresp", DATA_W'(bresp), DATA_W'(eb));
        end
        b_seen++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_rand) begin
      rready = 1'($urandom_range(0, 1));
      bready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_count(input string name, input bit is_r, input int target);
    int n = 0;
    while (((is_r ? r_seen : b_seen) < target) && n < 200) begin
      step(); n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no response within 200 cycles, required one", name);
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    int n = 0;
    int target;
    bit ar_busy_ok = 1'b1;
    r_q.push_back(model_read(a));
    target  = r_seen + 1;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0;
    check("r_lat_first_edge", DATA_W'(rvalid), '0);
    step();
    check("r_lat_second_edge", DATA_W'(rvalid), DATA_W'(1));
    n = 0;
    while (r_seen < target && n < 200) begin
      if (arready) ar_busy_ok = 1'b0;
      step(); n++;
    end
    check("arready_low_during_r", DATA_W'(ar_busy_ok), DATA_W'(1));
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL r_timeout: got no R handshake within 200 cycles, required one");
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DB-1:0] s, input int aw_dly, input int w_dly);
    int n = 0;
    int target;
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    b_q.push_back(model_write(a, d, s));
    target = b_seen + 1;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 60) begin
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      if (aw_done) check("wait_data_ready", DATA_W'({awready, wready}), DATA_W'(2'b01));
      if (w_done)  check("wait_addr_ready", DATA_W'({awready, wready}), DATA_W'(2'b10));
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step(); n++;
      aw_done |= hs_aw;
      w_done  |= hs_w;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("w_write_cycle", DATA_W'({awready, wready, bvalid}), DATA_W'(3'b000));
    step();
    check("w_resp_cycle", DATA_W'({awready, wready, bvalid}), DATA_W'(3'b001));
    wait_count("b", 1'b0, target);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DATA_W-1:0] d;
    rexp_t             e;
    int                rt, bt;

    repeat (3) step();
    check("reset_state",
          DATA_W'({rvalid, bvalid, rresp, bresp, arready, awready, wready}) | DATA_W'(rdata),
          DATA_W'(7'b0000111));
    rst = 1'b0;
    step();

    for (int w = 0; w < 32; w++) do_write(ADDR_W'(w * DB), rand_word(), '1, 0, 0);

    // Same-cycle AW+W with incrementing bytes, then read back.
    for (int i = 0; i < DB; i++) d[i*8 +: 8] = 8'(i);
    do_write(32'h40, d, 16'hFFFF, 0, 0);
    do_read(32'h40);

    // Single-lane update.
    d = rand_word();
    d[7:0] = 8'hAA;
    do_write(32'h40, d, 16'h0001, 0, 0);
    do_read(32'h40);

    // W leads AW by 3 cycles, then AW leads W by 3 cycles.
    do_write(32'h80, rand_word(), 16'hFFFF, 3, 0);
    do_read(32'h80);
    do_write(32'h90, rand_word(), 16'hF0F0, 0, 3);
    do_read(32'h90);

    // Read backpressure: rready low for 5 cycles while rvalid is up.
    rready = 1'b0;
    e = model_read(32'h80);
    r_q.push_back(e);
    rt = r_seen + 1;
    araddr = 32'h80; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_rvalid_arready", DATA_W'({rvalid, arready}), DATA_W'(2'b10));
      check("bp_rdata_stable", rdata, e.data);
      check("bp_rresp_stable", DATA_W'(rresp), DATA_W'(e.resp));
      step();
    end
    rready = 1'b1;
    wait_count("bp_r", 1'b1, rt);
    do_read(32'h90);

    // Out of range: the wrapped index would alias word 0, which must stay intact.
    do_write(32'h10000, rand_word(), 16'hFFFF, 0, 0);
    do_read(32'h10000);
    do_read(32'h0);
    do_write(32'hFFFF_FFF0, rand_word(), 16'hFFFF, 1, 0);
    do_read(32'hFFFF_FFF0);

    // Empty strobe, and misaligned address.
    do_write(32'h50, rand_word(), 16'h0000, 0, 0);
    do_read(32'h50);
    do_write(32'h41, rand_word(), 16'hFFFF, 0, 0);
    do_read(32'h40);
    do_read(32'h41);

    // Read accepted on the W_WRITE edge of a write to the same word sees old data.
    r_q.push_back(model_read(32'h40));
    rt = r_seen + 1;
    bt = b_seen + 1;
    awaddr = 32'h40; wdata = rand_word(); wstrb = 16'hFFFF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    b_q.push_back(model_write(32'h40, wdata, wstrb));
    araddr = 32'h40; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    wait_count("coll_r", 1'b1, rt);
    wait_count("coll_b", 1'b0, bt);
    do_read(32'h40);

    // Reset while the write response is pending.
    bready = 1'b0;
    awaddr = 32'h60; wdata = rand_word(); wstrb = 16'hFFFF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    void'(model_write(32'h60, wdata, wstrb));
    step();
    check("pre_reset_bvalid", DATA_W'(bvalid), DATA_W'(1));
    rst = 1'b1;
    step();
    check("reset_in_resp",
          DATA_W'({bvalid, rvalid, bresp, rresp, awready, wready, arready}) | DATA_W'(rdata),
          DATA_W'(7'b0000111));
    rst = 1'b0;
    bready = 1'b1;
    step();
    do_read(32'h60);

    // Randomised mixed traffic with random R/B backpressure.
    bp_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [ADDR_W-1:0] a;
      logic [DB-1:0]     s;
      case ($urandom_range(0, 7))
        0:       a = 32'h10000 + ADDR_W'($urandom_range(0, 511));
        1:       a = ADDR_W'($urandom_range(0, 31)) * DB;
        default: a = ADDR_W'($urandom_range(0, 511));
      endcase
      case ($urandom_range(0, 5))
        0:       s = '0;
        1:       s = '1;
        default: s = DB'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) do_read(a);
      else do_write(a, rand_word(), s, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    bp_rand = 1'b0;
    rready = 1'b1;
    bready = 1'b1;
    repeat (3) step();
    check("scoreboard_drained", DATA_W'(r_q.size() + b_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
